spi_word_target: RTL and testbench

//  SPI mode-0 target that deserialises the host SPI stream (SCK/CS/COPI) into

---
 rtl/spi_word_target.sv | 156 +++++++++++++++
 tb/tb_spi_word_target.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_target.sv
// SPI mode-0 target: deserialises COPI into WORD_BITS command words (byte 0 first,
// MSB first within a byte) and serialises a response word onto CIPO.
module spi_word_target #(
  parameter int unsigned WORD_BITS   = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sck,
  input  logic                 cs,
  input  logic                 copi,
  output logic                 cipo,
  output logic [WORD_BITS-1:0] rx_word,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  input  logic [WORD_BITS-1:0] tx_word,
  output logic                 tx_load,
  output logic                 busy
);

  localparam int unsigned NUM_BYTES = WORD_BITS / 8;
  localparam int unsigned BYTE_CW   = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [BYTE_CW-1:0] LAST_BYTE = BYTE_CW'(NUM_BYTES - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, copi_sync;
  logic sck_s, cs_s, copi_s, sck_d, cs_d;
  logic sck_rise, sck_fall, cs_fall;

  logic start_c, sample_c, advance_c, abort_c, word_last_c;
  logic [2:0]           bit_cnt;
  logic [BYTE_CW-1:0]   byte_cnt;
  logic [7:0]           byte_sr;
  logic [WORD_BITS-1:0] word_sr, tx_sr;
  logic                 done;

  // cs chain resets low so a cs held low through reset never reads as a falling edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      copi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign copi_s   = copi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    start_c     = 1'b0;
    sample_c    = 1'b0;
    advance_c   = 1'b0;
    abort_c     = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = SHIFT;
          start_c    = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          state_next = IDLE;
          abort_c    = 1'b1;
        end else begin
          sample_c  = sck_rise;
          advance_c = sck_fall;
        end
      end
      default: state_next = IDLE;
    endcase
    word_last_c = sample_c && (bit_cnt == 3'd7) && (byte_cnt == LAST_BYTE);
  end

  // Datapath; later assignments deliberately override earlier ones in the same clk
  always_ff @(posedge clk) begin
    if (reset) begin
      cipo       <= 1'b0;
      rx_word    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      tx_load    <= 1'b0;
      busy       <= 1'b0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      byte_sr    <= '0;
      word_sr    <= '0;
      tx_sr      <= '0;
      done       <= 1'b0;
    end else begin
      tx_load <= 1'b0;
      busy    <= (state_next == SHIFT);
      done    <= word_last_c;

      if (start_c) begin
        tx_sr   <= tx_word;
        tx_load <= 1'b1;
        cipo    <= tx_word[7];
      end

      if (sample_c) begin
        byte_sr <= {byte_sr[6:0], copi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          word_sr[{byte_cnt, 3'b000} +: 8] <= {byte_sr[6:0], copi_s};
          byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + BYTE_CW'(1);
        end
      end

      // counters already point at the next bit to be sampled
      if (advance_c) cipo <= tx_sr[{byte_cnt, ~bit_cnt}];

      if (done) begin
        rx_word  <= word_sr;
        rx_valid <= 1'b1;
        if (rx_valid && !rx_ready) rx_overrun <= 1'b1;
        if (state == SHIFT && state_next == SHIFT) begin
          tx_sr   <= tx_word;
          tx_load <= 1'b1;
          cipo    <= tx_word[7];
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (abort_c) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        cipo     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_word_target.sv
// Self-checking bench for spi_word_target: SPI host model at sck = clk/4 with a
// queue-based reference of received words and the expected CIPO bit stream.
module tb_spi_word_target;

  localparam int unsigned WB = 64;

  logic          clk = 1'b0;
  logic          reset, sck, cs, copi, cipo;
  logic [WB-1:0] rx_word, tx_word;
  logic          rx_valid, rx_ready, rx_overrun, tx_load, busy;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  logic [WB-1:0] acc_q[$];
  logic [WB-1:0] exp_q[$];
  logic [WB-1:0] cap;

  spi_word_target #(.WORD_BITS(64), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sck(sck), .cs(cs), .copi(copi), .cipo(cipo),
    .rx_word(rx_word), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_overrun(rx_overrun), .tx_word(tx_word), .tx_load(tx_load), .busy(busy)
  );

  always #5 clk = ~clk;

  // Accepted words and tx_load pulses observed away from the active edge
  always @(negedge clk) begin
    if (rx_valid && rx_ready) acc_q.push_back(rx_word);
    if (tx_load) load_cnt++;
  end

  // Serial order of a word on the wire: byte 0 first, MSB first
  function automatic logic [WB-1:0] ser(input logic [WB-1:0] w);
    logic [WB-1:0] s;
    for (int n = 0; n < WB; n++) s[n] = w[8*(n/8) + 7 - (n%8)];
    return s;
  endfunction

  function automatic logic [WB-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic send_bits(input logic [WB-1:0] w, input int nbits);
    logic [WB-1:0] s;
    s = ser(w);
    cap = '0;
    for (int n = 0; n < nbits; n++) begin
      copi = s[n];
      repeat (2) @(negedge clk);
      sck = 1'b1;
      repeat (2) @(negedge clk);
      cap[n] = cipo;
      sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 rx_ready = v;
  endtask

  task automatic test_reset();
    reset = 1'b1; sck = 1'b0; cs = 1'b1; copi = 1'b0; rx_ready = 1'b0; tx_word = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cipo !== 1'b0) begin errors++; $display("FAIL reset_cipo: got %b want 0", cipo); end
    checks++; if (rx_word !== '0) begin errors++; $display("FAIL reset_rx_word: got %h want 0", rx_word); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", rx_overrun); end
    checks++; if (tx_load !== 1'b0) begin errors++; $display("FAIL reset_tx_load: got %b want 0", tx_load); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_word();
    logic [WB-1:0] w;
    w = 64'hF200000000000000;
    set_ready(1'b0);
    tx_word = '0;
    cs_low();
    send_bits(w, 64);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_early: rx_valid got %b want 0", rx_valid); end
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_latency: rx_valid got %b want 1", rx_valid); end
    checks++; if (rx_word !== w) begin errors++; $display("FAIL single_word: got %h want %h", rx_word, w); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL single_overrun: got %b want 0", rx_overrun); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_in_frame: got %b want 1", busy); end
    cs_high();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b want 0", busy); end
    acc_q.delete();
    set_ready(1'b1);
    set_ready(1'b0);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_accept_clear: rx_valid got %b want 0", rx_valid); end
    checks++; if (acc_q.size() != 1) begin errors++; $display("FAIL single_accept_count: got %0d want 1", acc_q.size()); end
  endtask

  task automatic test_back_to_back();
    set_ready(1'b1);
    acc_q.delete();
    exp_q = '{64'hFFFFFFFFFFFFFFFF, 64'h01000000000000AA};
    cs_low();
    foreach (exp_q[i]) send_bits(exp_q[i], 64);
    cs_high();
    checks++;
    if (acc_q.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d want 2", acc_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_word%0d: got %h want %h", i, acc_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_tx_stream();
    logic [7:0] gb;
    tx_word = 64'h0123456789ABCDEF;
    load_cnt = 0;
    cs_low();
    send_bits(rnd64(), 64);
    cs_high();
    for (int k = 0; k < 8; k++) begin
      gb = '0;
      for (int i = 0; i < 8; i++) gb = {gb[6:0], cap[8*k + i]};
      checks++;
      if (gb !== tx_word[8*k +: 8]) begin errors++; $display("FAIL tx_byte%0d: got %h want %h", k, gb, tx_word[8*k +: 8]); end
    end
    checks++; if (load_cnt != 2) begin errors++; $display("FAIL tx_load_pulses: got %0d want 2", load_cnt); end
  endtask

  task automatic test_overrun();
    logic [WB-1:0] w1, w2;
    w1 = rnd64();
    w2 = rnd64();
    set_ready(1'b0);
    cs_low();
    send_bits(w1, 64);
    send_bits(w2, 64);
    cs_high();
    checks++; if (rx_word !== w2) begin errors++; $display("FAIL ovr_word: got %h want %h", rx_word, w2); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
    checks++; if (rx_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", rx_overrun); end
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({cipo, rx_word, rx_valid, rx_overrun, tx_load, busy} !== '0) begin
      errors++;
      $display("FAIL ovr_reset: got cipo=%b word=%h valid=%b ovr=%b load=%b busy=%b want all 0",
               cipo, rx_word, rx_valid, rx_overrun, tx_load, busy);
    end
  endtask

  task automatic test_abort();
    logic [WB-1:0] w;
    w = 64'hD000000000000000;
    set_ready(1'b1);
    acc_q.delete();
    cs_low();
    send_bits(rnd64(), 24);
    cs_high();
    checks++; if (acc_q.size() != 0) begin errors++; $display("FAIL abort_no_word: got %0d want 0", acc_q.size()); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL abort_overrun: got %b want 0", rx_overrun); end
    cs_low();
    send_bits(w, 64);
    cs_high();
    checks++;
    if (acc_q.size() != 1) begin
      errors++; $display("FAIL abort_count: got %0d want 1", acc_q.size());
    end else begin
      checks++;
      if (acc_q[0] !== w) begin errors++; $display("FAIL abort_word: got %h want %h", acc_q[0], w); end
    end
  endtask

  task automatic test_reset_mid();
    logic [WB-1:0] w;
    w = 64'h00000000005FFFFF;
    set_ready(1'b1);
    acc_q.delete();
    cs_low();
    send_bits(rnd64(), 12);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", rx_valid); end
    cs = 1'b1;
    repeat (6) @(negedge clk);
    cs_low();
    send_bits(w, 64);
    cs_high();
    checks++;
    if (acc_q.size() != 1) begin
      errors++; $display("FAIL rstmid_count: got %0d want 1", acc_q.size());
    end else begin
      checks++;
      if (acc_q[0] !== w) begin errors++; $display("FAIL rstmid_word: got %h want %h", acc_q[0], w); end
    end
  endtask

  task automatic test_random();
    logic [WB-1:0] d;
    int nw;
    set_ready(1'b1);
    for (int f = 0; f < 4; f++) begin
      acc_q.delete();
      exp_q.delete();
      nw = int'($urandom_range(1, 3));
      tx_word = rnd64();
      cs_low();
      for (int k = 0; k < nw; k++) begin
        d = rnd64();
        exp_q.push_back(d);
        send_bits(d, 64);
        checks++;
        if (cap !== ser(tx_word)) begin
          errors++; $display("FAIL rand_cipo f%0d w%0d: got %h want %h", f, k, cap, ser(tx_word));
        end
      end
      cs_high();
      checks++;
      if (acc_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rand_count f%0d: got %0d want %0d", f, acc_q.size(), exp_q.size());
      end else begin
        foreach (exp_q[i]) begin
          checks++;
          if (acc_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word f%0d w%0d: got %h want %h", f, i, acc_q[i], exp_q[i]); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_tx_stream();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
